// File: rtl/regfile_param_if.sv
// Register file access bundle: write port, two read ports, clear control.
// Decode and writeback drive the master side; the register file is the slave.
interface regfile_param_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            we_i;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] rd_in;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            clr_i;
    logic [XLEN-1:0] rs1_out;
    logic [XLEN-1:0] rs2_out;
    logic            busy_o;
    logic            wr_drop_o;

    modport master (
        output we_i, rd, rd_in, rs1, rs2, clr_i,
        input  rs1_out, rs2_out, busy_o, wr_drop_o
    );

    modport slave (
        input  we_i, rd, rd_in, rs1, rs2, clr_i,
        output rs1_out, rs2_out, busy_o, wr_drop_o
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file with clear sweep and dropped-write flag.
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rs_i,
    regfile_param_if.slave      bus
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

    localparam logic [AW-1:0] LAST = AW'(NREG - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] regs_q [NREG];

    logic            zero_rd;
    logic            wr_req;
    logic            wr_acc;
    logic            sweep;
    logic [XLEN-1:0] rs1_v;
    logic [XLEN-1:0] rs2_v;

    // Writes to a hardwired zero register are neither stored nor flagged.
    assign zero_rd = (ZERO_REG != 0) && (bus.rd == '0);
    assign wr_req  = bus.we_i && !zero_rd;
    assign wr_acc  = wr_req && (state_q == IDLE);
    assign sweep   = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        drop_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                drop_d = wr_req;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rs_i) begin
        if (rs_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    // Sweep and accepted writes are mutually exclusive by FSM state.
    always_ff @(posedge clk or posedge rs_i) begin
        if (rs_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (sweep) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_acc) begin
            regs_q[bus.rd] <= bus.rd_in;
        end
    end

    always_comb begin
        rs1_v = regs_q[bus.rs1];
        rs2_v = regs_q[bus.rs2];
        if ((ZERO_REG != 0) && (bus.rs1 == '0)) rs1_v = '0;
        if ((ZERO_REG != 0) && (bus.rs2 == '0)) rs2_v = '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_acc && (bus.rd == bus.rs1)) rs1_v = bus.rd_in;
        if (wr_acc && (bus.rd == bus.rs2)) rs2_v = bus.rd_in;
`else
        rs1_v = rs1_v;
        rs2_v = rs2_v;
`endif
    end

    assign bus.rs1_out   = rs1_v;
    assign bus.rs2_out   = rs2_v;
    assign bus.busy_o    = busy_q;
    assign bus.wr_drop_o = drop_q;

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
- Parametrised successor to the fixed 32x32 CPU register file.
- Width, depth and zero-register handling are configurable. Adds an explicit write enable, a multi-cycle clear sequencer with a busy flag, a dropped-write indication, and optional write-to-read forwarding.
- Sits in the DataFlow path between decode (rs1/rs2/rd selectors) and writeback (rd_in).

Parameters:
- XLEN, 32, data width of each register in bits.
- NREG, 32, number of registers; must equal 2**AW, range 2..32.
- AW, 5, selector width in bits.
- ZERO_REG, 1: 1 = index 0 always reads 0 and ignores writes; 0 = index 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rs_i  in  1  reset, asynchronous, active-high.
- we_i  in  1  write enable for port rd.
- rd  in  AW  destination register selector.
- rd_in  in  XLEN  write data.
- rs1  in  AW  read selector 1.
- rs2  in  AW  read selector 2.
- clr_i  in  1  start-clear request; sampled only in IDLE.
- rs1_out  out  XLEN  read data 1, combinational.
- rs2_out  out  XLEN  read data 2, combinational.
- busy_o  out  1  registered; high while clear sweep is in progress.
- wr_drop_o  out  1  registered one-cycle pulse; a write was discarded.

Behaviour:
- Interface: one clock, clk. rs_i is asynchronous and active-high.
- Reset (rs_i=1, takes effect immediately, independent of clk):
  - all NREG registers = 0
  - FSM = IDLE, sweep counter cnt = 0
  - busy_o = 0, wr_drop_o = 0
  - rs1_out/rs2_out therefore read 0.
- Reads are combinational: rsX_out = reg[rsX], zero latency. With ZERO_REG=1, rsX==0 always gives 0.
- Write acceptance: a write is accepted when we_i=1, FSM=IDLE, and not (ZERO_REG=1 and rd==0). An accepted write sets reg[rd] <= rd_in at the edge and is visible on reads the following cycle.
- Writes with we_i=0 have no effect. A write to rd==0 with ZERO_REG=1 is silently ignored and does not raise wr_drop_o.
- FSM states: IDLE, CLEAR.
- IDLE:
  - clr_i=1 -> CLEAR at next edge; cnt <= 0, busy_o <= 1.
  - A write in the same cycle as clr_i is accepted normally; the sweep then zeroes it.
- CLEAR:
  - Each edge: reg[cnt] <= 0, cnt <= cnt+1.
  - When cnt==NREG-1: that register is cleared, FSM -> IDLE, busy_o <= 0, cnt <= 0.
  - busy_o is high for exactly NREG cycles.
  - clr_i is ignored (no restart, no queueing).
  - Reads return current contents: entries below cnt are already zero, entries at or above cnt are old values.
  - we_i=1 (excluding ZERO_REG rd==0) is discarded; wr_drop_o=1 for the following cycle only. Back-to-back drops give a continuous high.
- cnt is AW bits wide; no wrap beyond NREG-1 is possible.
- Reset during CLEAR aborts the sweep immediately; all registers are 0 and the FSM is IDLE.
- No X is ever driven on outputs for any selector value.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If a write is being accepted this cycle and rd==rsX, rsX_out = rd_in combinationally in the same cycle.
  - Applies to rs1 and rs2 independently.
  - Never forwards to index 0 when ZERO_REG=1.
  - Never forwards dropped writes (FSM=CLEAR).
- Undefined: rsX_out shows the old register value until the edge; no forwarding logic is present.

Test Plan:
- Reset then read: assert rs_i mid-cycle with no clk edge -> rs1_out=rs2_out=0 immediately; busy_o=0, wr_drop_o=0.
- Basic write/read: write rd=5, rd_in=32'hDEADBEEF; next cycle rs1=5, rs2=5 -> both outputs 32'hDEADBEEF.
- Zero register: write rd=0, rd_in=32'h12345678 with ZERO_REG=1 -> rs1=0 reads 0, wr_drop_o stays 0. With ZERO_REG=0, rs1=0 reads 32'h12345678.
- Clear sweep:
  - Fill r1..r31 with index value, pulse clr_i -> busy_o high for exactly 32 cycles.
  - After 10 sweep edges, rs1=9 reads 0 and rs2=20 reads 20.
  - A write of rd=20 during CLEAR is dropped and wr_drop_o pulses 1 cycle.
  - After busy_o falls, all registers read 0.
- Reset mid-sweep: assert rs_i after 7 sweep cycles -> busy_o=0 at once, all reads 0; a new clr_i is accepted afterwards.
- Bypass:
  - With REGFILE_BYPASS_EN, we_i=1, rd=3, rd_in=32'hA5A5A5A5, rs1=3 -> rs1_out=32'hA5A5A5A5 in the same cycle.
  - Without the macro -> rs1_out shows the old value that cycle and 32'hA5A5A5A5 the next.
